// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60) and small helpers reused by the
// timing generator and downstream renderers.
package vga_pkg;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int VGA_HS_START = VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
  localparam int VGA_VS_START = VGA_V_DISPLAY + VGA_V_FRONT;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

  // Sync/DE flags carried through the delay line; hs/vs are "active", not pin levels.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } vga_sync_t;

  function automatic logic in_window(input int pos, input int lo, input int len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/vga_pix_strobe.sv
// Phase-accumulator pixel strobe: the accumulator carry becomes a one-clk
// pix_stb, giving a pixel rate of clk*STB_INC/65536.
module vga_pix_strobe #(
  parameter logic [15:0] STB_INC = 16'h4000
) (
  input  logic clk,
  input  logic reset,
  output logic pix_stb
);

  logic [15:0] acc;
  logic [16:0] sum;

  assign sum = {1'b0, acc} + {1'b0, STB_INC};

  // NOTE: clocked state always uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      pix_stb <= 1'b0;
    end else begin
      acc     <= sum[15:0];
      pix_stb <= sum[16];
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel strobe, position counters, delayed
// sync/DE with selectable polarity, line/frame markers and a frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter logic [15:0] STB_INC   = 16'h4000,
  parameter int          CW        = 11,
  parameter int          H_DISPLAY = VGA_H_DISPLAY,
  parameter int          H_FRONT   = VGA_H_FRONT,
  parameter int          H_SYNC    = VGA_H_SYNC,
  parameter int          H_BACK    = VGA_H_BACK,
  parameter int          V_DISPLAY = VGA_V_DISPLAY,
  parameter int          V_FRONT   = VGA_V_FRONT,
  parameter int          V_SYNC    = VGA_V_SYNC,
  parameter int          V_BACK    = VGA_V_BACK,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int          PIPE      = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          pix_stb,
  output logic [CW-1:0] hpos,
  output logic [CW-1:0] vpos,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_cnt
);

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int VS_START = V_DISPLAY + V_FRONT;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  if ((H_TOTAL > (1 << CW)) || (V_TOTAL > (1 << CW))) begin : g_bad_cw
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
  end
  if ((H_DISPLAY == 0) || (H_FRONT == 0) || (H_SYNC == 0) || (H_BACK == 0) ||
      (V_DISPLAY == 0) || (V_FRONT == 0) || (V_SYNC == 0) || (V_BACK == 0)) begin : g_bad_timing
    $error("vga_timing_gen: timing parameters must be non-zero");
  end
  if ((PIPE < 0) || (PIPE > 15)) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE must be in 0..15");
  end

  vga_pix_strobe #(.STB_INC(STB_INC)) u_pix_strobe (
    .clk     (clk),
    .reset   (reset),
    .pix_stb (pix_stb)
  );

  logic          advance;
  logic          h_wrap;
  logic          v_wrap;
  logic [CW-1:0] hpos_nxt;
  logic [CW-1:0] vpos_nxt;
  vga_sync_t     raw_nxt;

  assign advance = pix_stb && en;

  // Raw sync/DE are formed from the position about to be loaded, so the
  // PIPE=0 outputs line up with the counters they are shown alongside.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    h_wrap   = (hpos == H_LAST);
    v_wrap   = (vpos == V_LAST);
    hpos_nxt = h_wrap ? '0 : hpos + ONE;
    vpos_nxt = vpos;
    if (h_wrap) begin
      vpos_nxt = v_wrap ? '0 : vpos + ONE;
    end
    raw_nxt.hs = in_window(int'(hpos_nxt), HS_START, H_SYNC);
    raw_nxt.vs = in_window(int'(vpos_nxt), VS_START, V_SYNC);
    raw_nxt.de = in_window(int'(hpos_nxt), 0, H_DISPLAY) &&
                 in_window(int'(vpos_nxt), 0, V_DISPLAY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos        <= '0;
      vpos        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      line_start  <= advance && h_wrap;
      frame_start <= advance && h_wrap && v_wrap;
      if (advance) begin
        hpos <= hpos_nxt;
        vpos <= vpos_nxt;
        if (h_wrap && v_wrap) begin
          frame_cnt <= frame_cnt + 16'd1;
        end
      end
    end
  end

  // Stage 0 holds the current pixel; stage PIPE drives the pins.
  vga_sync_t dly [0:PIPE];

  // NOTE: this small register array is reset on purpose so sync/DE come out
  // inactive until real raster data has shifted through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= PIPE; i++) begin
        dly[i] <= '0;
      end
    end else if (advance) begin
      dly[0] <= raw_nxt;
      for (int i = 1; i <= PIPE; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  assign de    = dly[PIPE].de;
  assign hsync = HSYNC_POL ? dly[PIPE].hs : ~dly[PIPE].hs;
  assign vsync = VSYNC_POL ? dly[PIPE].vs : ~dly[PIPE].vs;

endmodule
